// File: rtl/prod_acc_pkg.sv
// rtl/prod_acc_pkg.sv - shared types and constants for the product accumulator
package prod_acc_pkg;

    // Width of the per-frame product counter and of out_count
    localparam int CNT_W = 8;

    // ACCUM collects products; HOLD presents a finished frame result
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // Largest value representable in w unsigned bits, used as the saturation ceiling
    function automatic int sat_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/prod_accumulator_sat_add.sv
// rtl/prod_accumulator_sat_add.sv - unsigned saturating adder with overflow flag
module sat_add
    import prod_acc_pkg::*;
#(
    parameter int ACC_W  = 10,
    parameter int PROD_W = 6
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    localparam logic [ACC_W-1:0] SUM_MAX = ACC_W'(sat_max(ACC_W));

    // One extra bit of headroom so the carry out is the overflow indicator
    logic [ACC_W:0] wide;

    // Add at ACC_W+1 bits, then clamp to all-ones when the carry is set
    always_comb begin
        wide = {1'b0, a} + (ACC_W + 1)'(b);
        ovf  = wide[ACC_W];
        sum  = ovf ? SUM_MAX : wide[ACC_W-1:0];
    end

endmodule

// File: rtl/prod_accumulator.sv
// rtl/prod_accumulator.sv - frame accumulator of multiplier products with valid/ready result
module prod_accumulator
    import prod_acc_pkg::*;
#(
    parameter int PROD_W    = 6,
    parameter int ACC_W     = 10,
    parameter int FRAME_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             accept;
    logic             close;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf_new;

    sat_add #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_sat_add (
        .a   (acc_q),
        .b   (in_prod),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // Next-state, accumulate path and frame-close loading of the result registers
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        // Handshake flags are derived from state only, so outputs stay registered
        in_ready    = (state_q == ACCUM);
        accept      = in_valid && in_ready;
        close       = accept && ((cnt_q == LAST_IDX) || in_flush);
        cnt_inc     = cnt_q + 1'b1;
        ovf_new     = ovf_q || add_ovf;

        unique case (state_q)
            ACCUM: begin
                if (close) begin
                    out_sum_d   = add_sum;
                    out_count_d = cnt_inc;
                    out_ovf_d   = ovf_new;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    state_d     = HOLD;
                end else if (accept) begin
                    acc_d = add_sum;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_new;
                end
            end
            HOLD: begin
                // Result registers are left untouched so the output is stable until taken
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State and datapath registers with synchronous reset discarding any partial work
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// tb/tb_prod_accumulator.sv - self-checking bench for prod_accumulator
module tb_prod_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: defaults; instance 1: ACC_W=7; instance 2: FRAME_LEN=1
    logic [2:0]      rst;
    logic [2:0]      in_valid;
    logic [2:0]      in_flush;
    logic [2:0]      out_ready;
    logic [2:0][5:0] in_prod;
    logic [2:0]      in_ready;
    logic [2:0]      out_valid;
    logic [2:0][9:0] out_sum;
    logic [2:0][7:0] out_count;
    logic [2:0]      out_ovf;
    logic [9:0]      sum0;
    logic [6:0]      sum1;
    logic [9:0]      sum2;

    assign out_sum[0] = sum0;
    assign out_sum[1] = {3'b000, sum1};
    assign out_sum[2] = sum2;

    prod_accumulator #(.PROD_W(6), .ACC_W(10), .FRAME_LEN(4)) u_dut0 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_prod(in_prod[0]), .in_flush(in_flush[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_sum(sum0), .out_count(out_count[0]), .out_ovf(out_ovf[0])
    );

    prod_accumulator #(.PROD_W(6), .ACC_W(7), .FRAME_LEN(4)) u_dut1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_prod(in_prod[1]), .in_flush(in_flush[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_sum(sum1), .out_count(out_count[1]), .out_ovf(out_ovf[1])
    );

    prod_accumulator #(.PROD_W(6), .ACC_W(10), .FRAME_LEN(1)) u_dut2 (
        .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_prod(in_prod[2]), .in_flush(in_flush[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_sum(sum2), .out_count(out_count[2]), .out_ovf(out_ovf[2])
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    int cfg_max[3] = '{1023, 127, 1023};
    int cfg_fl[3]  = '{4, 4, 1};

    // Model state: running frame sum/count/overflow, held result, and whether a result is pending
    int m_sum[3];
    int m_cnt[3];
    int m_ovf[3];
    int m_hold[3];
    int m_rsum[3];
    int m_rcnt[3];
    int m_rovf[3];

    // Handshaken results encoded as inst*1000000 + sum*1000 + count*10 + ovf
    int got_log[$];

    task automatic check(input string nm, input int inst, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0d want=%0d at %0t", nm, inst, act, exp, $time);
        end
    endtask

    // Frame-level model advanced on each clock edge from the inputs it sees
    initial begin
        for (int i = 0; i < 3; i++) begin
            m_sum[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_hold[i] = 0;
            m_rsum[i] = 0; m_rcnt[i] = 0; m_rovf[i] = 0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rst[i]) begin
                    m_sum[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_hold[i] = 0;
                    m_rsum[i] = 0; m_rcnt[i] = 0; m_rovf[i] = 0;
                end else if (m_hold[i] != 0) begin
                    if (out_ready[i]) m_hold[i] = 0;
                end else if (in_valid[i]) begin
                    m_sum[i] = m_sum[i] + int'(in_prod[i]);
                    if (m_sum[i] > cfg_max[i]) begin
                        m_sum[i] = cfg_max[i];
                        m_ovf[i] = 1;
                    end
                    m_cnt[i]++;
                    if (m_cnt[i] == cfg_fl[i] || in_flush[i]) begin
                        m_rsum[i] = m_sum[i]; m_rcnt[i] = m_cnt[i]; m_rovf[i] = m_ovf[i];
                        m_sum[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_hold[i] = 1;
                    end
                end
            end
        end
    end

    // Compare every output of every instance against the model on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 3; i++) begin
                    check("in_ready", i, int'(in_ready[i]), (m_hold[i] == 0) ? 1 : 0);
                    check("out_valid", i, int'(out_valid[i]), m_hold[i]);
                    check("out_sum", i, int'(out_sum[i]), m_rsum[i]);
                    check("out_count", i, int'(out_count[i]), m_rcnt[i]);
                    check("out_ovf", i, int'(out_ovf[i]), m_rovf[i]);
                    if (out_valid[i] && out_ready[i])
                        got_log.push_back(i * 1000000 + int'(out_sum[i]) * 1000
                                          + int'(out_count[i]) * 10 + int'(out_ovf[i]));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one product and hold it until the block takes it, bounded to 20 cycles
    task automatic send(input int i, input int p, input bit f);
        bit rdy;
        bit ok;
        ok = 1'b0;
        in_valid[i] = 1'b1;
        in_prod[i]  = 6'(p);
        in_flush[i] = f;
        for (int k = 0; k < 20; k++) begin
            rdy = in_ready[i];
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid[i] = 1'b0;
        in_flush[i] = 1'b0;
        if (!ok) check("send_timeout", i, 0, 1);
    endtask

    int exp_log[$];

    initial begin
        rst       = 3'b111;
        in_valid  = '0;
        in_flush  = '0;
        out_ready = 3'b111;
        in_prod   = '0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        idle(1);
        rst = 3'b000;

        // Reset state, pinned by constants
        check("rst_out_valid", 0, int'(out_valid[0]), 0);
        check("rst_in_ready", 0, int'(in_ready[0]), 1);
        check("rst_out_sum", 0, int'(out_sum[0]), 0);
        check("rst_out_count", 0, int'(out_count[0]), 0);

        // Basic frame
        send(0, 6, 0); send(0, 9, 0); send(0, 4, 0); send(0, 49, 0);
        check("basic_valid", 0, int'(out_valid[0]), 1);
        check("basic_sum", 0, int'(out_sum[0]), 68);
        check("basic_ready_low", 0, int'(in_ready[0]), 0);
        idle(1);
        check("basic_ready_back", 0, int'(in_ready[0]), 1);

        // Early flush, then a fresh frame from zero
        send(0, 12, 0); send(0, 20, 1);
        check("flush_count", 0, int'(out_count[0]), 2);
        send(0, 3, 0); send(0, 3, 0); send(0, 3, 0); send(0, 3, 0);
        idle(1);

        // Backpressure with refused input pulses
        out_ready[0] = 1'b0;
        send(0, 1, 0); send(0, 2, 0); send(0, 3, 0); send(0, 4, 0);
        for (int k = 0; k < 5; k++) begin
            in_valid[0] = 1'b1;
            in_prod[0]  = 6'd7;
            check("bp_sum_stable", 0, int'(out_sum[0]), 10);
            check("bp_in_ready", 0, int'(in_ready[0]), 0);
            idle(1);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        idle(2);

        // Gaps then reset mid-frame; only the following frame may produce a result
        send(0, 5, 0); idle(3); send(0, 7, 0);
        rst[0] = 1'b1;
        idle(1);
        rst[0] = 1'b0;
        check("rst2_sum", 0, int'(out_sum[0]), 0);
        check("rst2_count", 0, int'(out_count[0]), 0);
        check("rst2_valid", 0, int'(out_valid[0]), 0);
        send(0, 2, 0); send(0, 2, 0); send(0, 2, 0); send(0, 2, 0);
        idle(2);

        // Saturation with ACC_W=7
        send(1, 49, 0); send(1, 49, 0); send(1, 49, 0); send(1, 1, 0);
        check("sat_sum", 1, int'(out_sum[1]), 127);
        check("sat_ovf", 1, int'(out_ovf[1]), 1);
        send(1, 1, 0); send(1, 1, 0); send(1, 1, 0); send(1, 1, 0);
        idle(2);

        // FRAME_LEN=1
        send(2, 9, 0);
        check("fl1_count", 2, int'(out_count[2]), 1);
        send(2, 25, 0);
        idle(3);

        chk_en = 1'b0;
        exp_log = '{68040, 32020, 12040, 10040, 8040,
                    1127041, 1004040, 2009010, 2025010};
        check("log_len", 0, got_log.size(), exp_log.size());
        for (int k = 0; k < exp_log.size() && k < got_log.size(); k++)
            check("log_entry", k, got_log[k], exp_log[k]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
